// File: rtl/sprite_line_fetcher_if.sv
// Bundled control, ROM and pixel signals of sprite_line_fetcher.
// Macro SPRITE_HFLIP_EN adds the per-sprite horizontal-flip input.
interface sprite_line_fetcher_if #(
  parameter int NSPR = 6
);
  logic                   i_line_start;
  logic [9:0]             i_next_line;
  logic [20*NSPR-1:0]     i_spr_pos;
  logic [14*NSPR-1:0]     i_spr_base;
  logic [13:0]            o_rom_addr;
  logic [7:0]             i_rom_data;
  logic [9:0]             i_hcount;
  logic [7:0]             o_pix;
  logic                   o_pix_valid;
  logic                   o_busy;
  logic                   o_overrun;
`ifdef SPRITE_HFLIP_EN
  logic [NSPR-1:0]        i_hflip;

  modport slave (
    input  i_line_start, i_next_line, i_spr_pos, i_spr_base, i_rom_data, i_hcount, i_hflip,
    output o_rom_addr, o_pix, o_pix_valid, o_busy, o_overrun
  );
  modport master (
    output i_line_start, i_next_line, i_spr_pos, i_spr_base, i_rom_data, i_hcount, i_hflip,
    input  o_rom_addr, o_pix, o_pix_valid, o_busy, o_overrun
  );
`else
  modport slave (
    input  i_line_start, i_next_line, i_spr_pos, i_spr_base, i_rom_data, i_hcount,
    output o_rom_addr, o_pix, o_pix_valid, o_busy, o_overrun
  );
  modport master (
    output i_line_start, i_next_line, i_spr_pos, i_spr_base, i_rom_data, i_hcount,
    input  o_rom_addr, o_pix, o_pix_valid, o_busy, o_overrun
  );
`endif
endinterface

// File: rtl/sprite_line_fetcher.sv
// Fetches 16-pixel sprite rows into a line buffer during blanking and mixes them by priority.
// Optional macro SPRITE_HFLIP_EN mirrors a sprite's row as it is written.
module sprite_line_fetcher #(
  parameter int NSPR    = 6,
  parameter int SHEET_W = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  sprite_line_fetcher_if.slave  bus
);
  localparam int IW = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSPR - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {IDLE, CHECK, FETCH, FLUSH} state_t;
  state_t r_state, w_state_next;

  logic [IW-1:0]   r_idx;
  logic [3:0]      r_col;
  logic [NSPR-1:0] r_hit;
  logic [9:0]      r_line;
  logic [9:0]      r_hpos [NSPR];
  logic [9:0]      r_vpos [NSPR];
  logic [13:0]     r_base [NSPR];
  logic [13:0]     r_rom_addr;
  logic            r_overrun;
  logic            r_wr_en;
  logic [IW-1:0]   r_wr_idx;
  logic [3:0]      r_wr_col;
  logic [7:0]      r_buf [NSPR][16];
  logic [7:0]      r_pix;
  logic            r_pix_valid;

  logic            w_busy;
  logic [9:0]      w_row;
  logic            w_row_hit;
  logic [13:0]     w_fetch_addr;
  logic [3:0]      w_wr_slot;
  logic [NSPR-1:0] w_cov;
  logic [7:0]      w_val [NSPR];
  logic [7:0]      w_win_pix;
  logic            w_win_valid;

  assign w_busy       = (r_state != IDLE);
  assign w_row        = r_line - r_vpos[r_idx];
  assign w_row_hit    = (w_row < 10'd16);
  assign w_fetch_addr = r_base[r_idx] + 14'(w_row[3:0]) * 14'(SHEET_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // A line_start in any state restarts the scan from sprite 0.
  always_comb begin
    w_state_next = r_state;
    if (bus.i_line_start) begin
      w_state_next = CHECK;
    end else begin
      case (r_state)
        IDLE:    w_state_next = IDLE;
        CHECK:   w_state_next = w_row_hit ? FETCH : ((r_idx == LAST) ? IDLE : CHECK);
        FETCH:   w_state_next = (r_col == 4'd15) ? FLUSH : FETCH;
        FLUSH:   w_state_next = (r_idx == LAST) ? IDLE : CHECK;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_col      <= '0;
      r_hit      <= '0;
      r_line     <= '0;
      r_rom_addr <= '0;
      r_overrun  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_idx   <= '0;
      r_wr_col   <= '0;
    end else begin
      // ROM data lags the address by one cycle, so the write is a delayed copy of FETCH.
      r_wr_en  <= (r_state == FETCH);
      r_wr_idx <= r_idx;
      r_wr_col <= r_col;
      if (bus.i_line_start) begin
        r_line <= bus.i_next_line;
        r_idx  <= '0;
        if (w_busy) begin
          r_overrun <= 1'b1;
          r_hit     <= '0;
        end
      end else begin
        case (r_state)
          CHECK: begin
            r_hit[r_idx] <= w_row_hit;
            if (w_row_hit) begin
              r_col      <= '0;
              r_rom_addr <= w_fetch_addr;
            end else if (r_idx != LAST) begin
              r_idx <= r_idx + ONE;
            end
          end
          FETCH: begin
            r_col <= r_col + 4'd1;
            if (r_col != 4'd15) r_rom_addr <= r_rom_addr + 14'd1;
          end
          FLUSH: if (r_idx != LAST) r_idx <= r_idx + ONE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.i_line_start) begin
      for (int k = 0; k < NSPR; k++) begin
        r_hpos[k] <= bus.i_spr_pos[20*k+10 +: 10];
        r_vpos[k] <= bus.i_spr_pos[20*k +: 10];
        r_base[k] <= bus.i_spr_base[14*k +: 14];
      end
    end
  end

`ifdef SPRITE_HFLIP_EN
  logic [NSPR-1:0] r_hflip;
  logic            r_wr_flip;
  always_ff @(posedge clk) begin
    if (bus.i_line_start) r_hflip <= bus.i_hflip;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr_flip <= 1'b0;
    else     r_wr_flip <= r_hflip[r_idx];
  end
  assign w_wr_slot = r_wr_flip ? ~r_wr_col : r_wr_col;
`else
  assign w_wr_slot = r_wr_col;
`endif

  always_ff @(posedge clk) begin
    if (r_wr_en) r_buf[r_wr_idx][w_wr_slot] <= bus.i_rom_data;
  end

  // Sprite covers hcount when hpos+1 <= hcount <= hpos+16 (10-bit wrap).
  genvar gi;
  generate
    for (gi = 0; gi < NSPR; gi++) begin : g_pix
      logic [9:0] w_d;
      logic [3:0] w_pcol;
      assign w_d        = bus.i_hcount - r_hpos[gi];
      assign w_pcol     = 4'(w_d - 10'd1);
      assign w_cov[gi]  = r_hit[gi] && (w_d != 10'd0) && (w_d <= 10'd16);
      assign w_val[gi]  = r_buf[gi][w_pcol];
    end
  endgenerate

  always_comb begin
    w_win_valid = 1'b0;
    w_win_pix   = 8'h00;
    for (int k = NSPR - 1; k >= 0; k--) begin
      if (w_cov[k] && (w_val[k] != 8'hFF)) begin
        w_win_valid = 1'b1;
        w_win_pix   = w_val[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix       <= 8'h00;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix       <= w_win_pix;
      r_pix_valid <= w_win_valid;
    end
  end

  assign bus.o_rom_addr  = r_rom_addr;
  assign bus.o_pix       = r_pix;
  assign bus.o_pix_valid = r_pix_valid;
  assign bus.o_busy      = w_busy;
  assign bus.o_overrun   = r_overrun;
endmodule
